mem_wb_stage: RTL and testbench

- MEM→WB stage of the soft CPU; consumes the MEM-stage pipeline registers (ALU result, LUI immediate, PC+4, load request) and drives the register-file write port.
- Aligns and extends load data, waits on the data-memory ready handshake with timeout, and back-pressures the MEM stage while a load is outstanding.
- Advances only on ClockEnable & Tick, matching the gating of the MEM-stage registers.

---
 rtl/mem_wb_if.sv | 39 +++
 rtl/mem_wb_stage.sv | 186 ++++++++++++++++++
 tb/tb_mem_wb_stage.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_wb_if.sv
// MEM->WB stage bus: MEM-stage pipeline inputs, data-memory read return,
// register-file write port, hazard and error status.
interface mem_wb_if #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned RA_BITS = 5
);
    logic               in_valid;
    logic               in_ready;
    logic [RA_BITS-1:0] in_rd;
    logic [1:0]         in_wb_sel;
    logic [XLEN-1:0]    in_alu;
    logic [XLEN-1:0]    in_lui_imm;
    logic [XLEN-1:0]    in_pc4;
    logic [2:0]         in_funct3;
    logic               flush;
    logic [XLEN-1:0]    dmem_rdata;
    logic               dmem_ready;
    logic               err_clr;
    logic               rf_we;
    logic [RA_BITS-1:0] rf_waddr;
    logic [XLEN-1:0]    rf_wdata;
    logic               busy;
    logic [RA_BITS-1:0] busy_rd;
    logic               err;
    logic [1:0]         err_code;

    // Upstream pipeline, memory and register file as seen from outside the stage.
    modport master (
        output in_valid, in_rd, in_wb_sel, in_alu, in_lui_imm, in_pc4, in_funct3, flush,
        output dmem_rdata, dmem_ready, err_clr,
        input  in_ready, rf_we, rf_waddr, rf_wdata, busy, busy_rd, err, err_code
    );

    modport slave (
        input  in_valid, in_rd, in_wb_sel, in_alu, in_lui_imm, in_pc4, in_funct3, flush,
        input  dmem_rdata, dmem_ready, err_clr,
        output in_ready, rf_we, rf_waddr, rf_wdata, busy, busy_rd, err, err_code
    );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM->WB pipeline stage: selects write-back source, performs aligned loads with a
// ready/timeout handshake, and drives the register-file write port.
module mem_wb_stage #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned RA_BITS     = 5,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic  Clock,
    input  logic  Reset,
    input  logic  ClockEnable,
    input  logic  Tick,
    mem_wb_if.slave bus
);
    localparam int unsigned TIMER_BITS = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [TIMER_BITS-1:0] TIMER_LAST = TIMER_BITS'(MEM_TIMEOUT - 1);

    localparam logic [1:0] WB_ALU  = 2'b00;
    localparam logic [1:0] WB_LOAD = 2'b01;
    localparam logic [1:0] WB_LUI  = 2'b10;
    localparam logic [1:0] WB_PC4  = 2'b11;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_ALIGN   = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    typedef enum logic [0:0] {StRun, StWait} state_e;

    state_e               state_q, state_d;
    logic                 rf_we_q, rf_we_d;
    logic [RA_BITS-1:0]   rf_waddr_q, rf_waddr_d;
    logic [XLEN-1:0]      rf_wdata_q, rf_wdata_d;
    logic                 err_q, err_d;
    logic [1:0]           err_code_q, err_code_d;
    logic [TIMER_BITS-1:0] timer_q, timer_d;
    logic [RA_BITS-1:0]   ld_rd_q, ld_rd_d;
    logic [2:0]           ld_f3_q, ld_f3_d;
    logic [1:0]           ld_addr_q, ld_addr_d;

    logic                 adv;
    logic                 accept;
    logic                 load_bad;
    logic [XLEN-1:0]      sel_data;
    logic [7:0]           ld_byte;
    logic [15:0]          ld_half;
    logic [XLEN-1:0]      ld_data;

    assign adv    = ClockEnable & Tick;
    assign accept = bus.in_valid & bus.in_ready & adv & ~bus.flush;

    assign bus.in_ready = (state_q == StRun);
    assign bus.busy     = (state_q == StWait);
    assign bus.busy_rd  = (state_q == StWait) ? ld_rd_q : '0;
    assign bus.rf_we    = rf_we_q;
    assign bus.rf_waddr = rf_waddr_q;
    assign bus.rf_wdata = rf_wdata_q;
    assign bus.err      = err_q;
    assign bus.err_code = err_code_q;

    always_comb begin
        sel_data = bus.in_alu;
        case (bus.in_wb_sel)
            WB_LUI:  sel_data = bus.in_lui_imm;
            WB_PC4:  sel_data = bus.in_pc4;
            default: sel_data = bus.in_alu;
        endcase
    end

    // Alignment is checked on the incoming address, before any memory handshake.
    always_comb begin
        load_bad = 1'b0;
        case (bus.in_funct3)
            F3_LB, F3_LBU: load_bad = 1'b0;
            F3_LH, F3_LHU: load_bad = bus.in_alu[0];
            F3_LW:         load_bad = |bus.in_alu[1:0];
            default:       load_bad = 1'b1;
        endcase
    end

    assign ld_byte = bus.dmem_rdata[{ld_addr_q, 3'b000} +: 8];
    assign ld_half = bus.dmem_rdata[{ld_addr_q[1], 4'b0000} +: 16];

    always_comb begin
        ld_data = bus.dmem_rdata;
        case (ld_f3_q)
            F3_LB:   ld_data = {{(XLEN-8){ld_byte[7]}}, ld_byte};
            F3_LBU:  ld_data = {{(XLEN-8){1'b0}}, ld_byte};
            F3_LH:   ld_data = {{(XLEN-16){ld_half[15]}}, ld_half};
            F3_LHU:  ld_data = {{(XLEN-16){1'b0}}, ld_half};
            default: ld_data = bus.dmem_rdata;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        err_d      = err_q;
        err_code_d = err_code_q;
        timer_d    = timer_q;
        ld_rd_d    = ld_rd_q;
        ld_f3_d    = ld_f3_q;
        ld_addr_d  = ld_addr_q;

        // Clear first so an error raised on this same edge overrides it.
        if (bus.err_clr) begin
            err_d      = 1'b0;
            err_code_d = ERR_NONE;
        end

        case (state_q)
            StRun: begin
                if (accept) begin
                    if (bus.in_wb_sel == WB_LOAD) begin
                        ld_rd_d   = bus.in_rd;
                        ld_f3_d   = bus.in_funct3;
                        ld_addr_d = bus.in_alu[1:0];
                        timer_d   = '0;
                        if (load_bad) begin
                            err_d      = 1'b1;
                            err_code_d = ERR_ALIGN;
                        end else begin
                            state_d = StWait;
                        end
                    end else begin
                        rf_we_d    = (bus.in_rd != '0);
                        rf_waddr_d = bus.in_rd;
                        rf_wdata_d = sel_data;
                    end
                end
            end
            StWait: begin
                if (bus.flush) begin
                    state_d = StRun;
                    timer_d = '0;
                end else if (bus.dmem_ready) begin
                    rf_we_d    = (ld_rd_q != '0);
                    rf_waddr_d = ld_rd_q;
                    rf_wdata_d = ld_data;
                    state_d    = StRun;
                    timer_d    = '0;
                end else if (timer_q == TIMER_LAST) begin
                    err_d      = 1'b1;
                    err_code_d = ERR_TIMEOUT;
                    state_d    = StRun;
                    timer_d    = '0;
                end else begin
                    timer_d = timer_q + TIMER_BITS'(1);
                end
            end
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q    <= StRun;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
            timer_q    <= '0;
            ld_rd_q    <= '0;
            ld_f3_q    <= '0;
            ld_addr_q  <= '0;
        end else if (adv) begin
            state_q    <= state_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
            timer_q    <= timer_d;
            ld_rd_q    <= ld_rd_d;
            ld_f3_q    <= ld_f3_d;
            ld_addr_q  <= ld_addr_d;
        end
    end
endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed vectors, a transaction-level model compared every
// cycle, plus literal expectations at key points.
module tb_mem_wb_stage;
    localparam int unsigned XLEN        = 32;
    localparam int unsigned RA_BITS     = 5;
    localparam int unsigned MEM_TIMEOUT = 15;

    logic Clock = 1'b0;
    logic Reset;
    logic ClockEnable;
    logic Tick;

    int vectors     = 0;
    int miscompares = 0;

    mem_wb_if #(.XLEN(XLEN), .RA_BITS(RA_BITS)) bus ();

    mem_wb_stage #(.XLEN(XLEN), .RA_BITS(RA_BITS), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .ClockEnable (ClockEnable),
        .Tick        (Tick),
        .bus         (bus)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: an outstanding load is just "pending" plus a count of wait edges seen.
    bit          m_pending;
    logic [4:0]  m_rd;
    logic [2:0]  m_f3;
    logic [1:0]  m_addr;
    int          m_waited;
    bit          m_we;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;
    bit          m_err;
    logic [1:0]  m_code;

    function automatic bit model_legal(input logic [2:0] f3, input logic [1:0] a);
        case (f3)
            3'd0, 3'd4: return 1'b1;
            3'd1, 3'd5: return (a % 2) == 0;
            3'd2:       return a == 0;
            default:    return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] a,
                                               input logic [31:0] w);
        logic [31:0] b;
        logic [31:0] h;
        b = (w >> (8 * a)) & 32'hFF;
        h = (w >> (16 * (a / 2))) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 128) ? (b | 32'hFFFF_FF00) : b;
            3'd4:    return b;
            3'd1:    return (h >= 32768) ? (h | 32'hFFFF_0000) : h;
            3'd5:    return h;
            default: return w;
        endcase
    endfunction

    task automatic model_step();
        if (Reset) begin
            m_pending = 0; m_waited = 0; m_we = 0; m_waddr = 0; m_wdata = 0;
            m_err = 0; m_code = 0;
        end else if (ClockEnable && Tick) begin
            m_we = 0;
            if (bus.err_clr) begin
                m_err = 0; m_code = 0;
            end
            if (!m_pending) begin
                if (bus.in_valid && !bus.flush) begin
                    if (bus.in_wb_sel == 2'b01) begin
                        if (model_legal(bus.in_funct3, bus.in_alu[1:0])) begin
                            m_pending = 1; m_waited = 0;
                            m_rd = bus.in_rd; m_f3 = bus.in_funct3; m_addr = bus.in_alu[1:0];
                        end else begin
                            m_err = 1; m_code = 2'b01;
                        end
                    end else begin
                        m_we    = (bus.in_rd != 0);
                        m_waddr = bus.in_rd;
                        m_wdata = (bus.in_wb_sel == 2'b10) ? bus.in_lui_imm :
                                  (bus.in_wb_sel == 2'b11) ? bus.in_pc4 : bus.in_alu;
                    end
                end
            end else if (bus.flush) begin
                m_pending = 0;
            end else if (bus.dmem_ready) begin
                m_pending = 0;
                m_we      = (m_rd != 0);
                m_waddr   = m_rd;
                m_wdata   = model_load(m_f3, m_addr, bus.dmem_rdata);
            end else begin
                m_waited++;
                if (m_waited == MEM_TIMEOUT) begin
                    m_pending = 0; m_err = 1; m_code = 2'b10;
                end
            end
        end
    endtask

    always @(posedge Clock) begin
        model_step();
        #1;
        if (!Reset) begin
            check("model rf_we", {31'd0, bus.rf_we}, {31'd0, m_we});
            check("model busy", {31'd0, bus.busy}, {31'd0, m_pending});
            check("model busy_rd", {27'd0, bus.busy_rd}, m_pending ? {27'd0, m_rd} : 32'd0);
            check("model in_ready", {31'd0, bus.in_ready}, {31'd0, !m_pending});
            check("model err", {31'd0, bus.err}, {31'd0, m_err});
            check("model err_code", {30'd0, bus.err_code}, {30'd0, m_code});
            if (m_we) begin
                check("model rf_waddr", {27'd0, bus.rf_waddr}, {27'd0, m_waddr});
                check("model rf_wdata", bus.rf_wdata, m_wdata);
            end
        end
    end

    task automatic cyc();
        @(negedge Clock);
    endtask

    task automatic idle();
        bus.in_valid = 0; bus.flush = 0; bus.dmem_ready = 0; bus.err_clr = 0;
    endtask

    task automatic issue(input logic [1:0] sel, input logic [4:0] rd, input logic [2:0] f3,
                         input logic [31:0] alu);
        bus.in_valid = 1; bus.in_wb_sel = sel; bus.in_rd = rd; bus.in_funct3 = f3;
        bus.in_alu = alu;
    endtask

    task automatic run_load(input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] word, input logic [31:0] exp, input string name);
        issue(2'b01, 5'd7, f3, addr);
        cyc();
        idle();
        bus.dmem_rdata = word;
        bus.dmem_ready = 1;
        cyc();
        check({name, " wdata"}, bus.rf_wdata, exp);
        bus.dmem_ready = 0;
    endtask

    initial begin
        Reset = 1; ClockEnable = 1; Tick = 1;
        idle();
        bus.in_rd = 0; bus.in_wb_sel = 0; bus.in_alu = 0; bus.in_lui_imm = 32'hABCDE000;
        bus.in_pc4 = 32'h104; bus.in_funct3 = 0; bus.dmem_rdata = 0;
        repeat (2) cyc();
        check("reset rf_we", {31'd0, bus.rf_we}, 32'd0);
        check("reset in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("reset err_code", {30'd0, bus.err_code}, 32'd0);
        Reset = 0;
        cyc();

        issue(2'b00, 5'd3, 3'd0, 32'h12345678);
        cyc();
        check("alu we", {31'd0, bus.rf_we}, 32'd1);
        check("alu waddr", {27'd0, bus.rf_waddr}, 32'd3);
        check("alu wdata", bus.rf_wdata, 32'h12345678);
        idle();
        cyc();
        check("alu we drop", {31'd0, bus.rf_we}, 32'd0);
        issue(2'b10, 5'd4, 3'd0, 32'h0);
        cyc();
        check("lui wdata", bus.rf_wdata, 32'hABCDE000);
        issue(2'b11, 5'd6, 3'd0, 32'h0);
        cyc();
        check("pc4 wdata", bus.rf_wdata, 32'h104);
        check("b2b we", {31'd0, bus.rf_we}, 32'd1);
        idle();
        cyc();

        // LB waits three edges for ready after acceptance.
        issue(2'b01, 5'd7, 3'd0, 32'h1003);
        cyc();
        check("lb busy", {31'd0, bus.busy}, 32'd1);
        check("lb busy_rd", {27'd0, bus.busy_rd}, 32'd7);
        idle();
        bus.dmem_rdata = 32'h80FF7F01;
        repeat (2) cyc();
        check("lb still busy", {31'd0, bus.busy}, 32'd1);
        bus.dmem_ready = 1;
        cyc();
        check("lb we", {31'd0, bus.rf_we}, 32'd1);
        check("lb wdata", bus.rf_wdata, 32'hFFFFFF80);
        check("lb done", {31'd0, bus.busy}, 32'd0);
        idle();
        run_load(3'd4, 32'h1003, 32'h80FF7F01, 32'h00000080, "lbu");
        run_load(3'd1, 32'h1002, 32'h80FF7F01, 32'hFFFF80FF, "lh");
        run_load(3'd5, 32'h1000, 32'h80FF7F01, 32'h00007F01, "lhu");
        run_load(3'd2, 32'h1000, 32'h80FF7F01, 32'h80FF7F01, "lw");

        issue(2'b01, 5'd7, 3'd2, 32'h1002);
        cyc();
        check("lw mis err_code", {30'd0, bus.err_code}, 32'd1);
        check("lw mis in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("lw mis we", {31'd0, bus.rf_we}, 32'd0);
        // New error on the clearing edge must win.
        issue(2'b01, 5'd7, 3'd1, 32'h1001);
        bus.err_clr = 1;
        cyc();
        check("clr vs new err", {31'd0, bus.err}, 32'd1);
        idle();
        issue(2'b01, 5'd7, 3'd3, 32'h1000);
        cyc();
        check("bad funct3 err", {30'd0, bus.err_code}, 32'd1);
        idle();
        bus.err_clr = 1;
        cyc();
        check("err_clr", {31'd0, bus.err}, 32'd0);
        idle();

        issue(2'b01, 5'd8, 3'd2, 32'h2000);
        cyc();
        idle();
        repeat (MEM_TIMEOUT - 1) cyc();
        check("timeout pre busy", {31'd0, bus.busy}, 32'd1);
        cyc();
        check("timeout busy", {31'd0, bus.busy}, 32'd0);
        check("timeout err_code", {30'd0, bus.err_code}, 32'd2);
        bus.err_clr = 1;
        cyc();
        idle();

        issue(2'b01, 5'd9, 3'd2, 32'h3000);
        cyc();
        idle();
        bus.flush = 1; bus.dmem_ready = 1;
        cyc();
        check("flush+ready we", {31'd0, bus.rf_we}, 32'd0);
        check("flush+ready busy", {31'd0, bus.busy}, 32'd0);
        idle();

        issue(2'b00, 5'd0, 3'd0, 32'hDEADBEEF);
        cyc();
        check("x0 we", {31'd0, bus.rf_we}, 32'd0);
        issue(2'b00, 5'd11, 3'd0, 32'h55);
        bus.flush = 1;
        cyc();
        check("run flush we", {31'd0, bus.rf_we}, 32'd0);
        idle();

        issue(2'b00, 5'd12, 3'd0, 32'hCAFE0001);
        cyc();
        issue(2'b00, 5'd10, 3'd0, 32'h77);
        Tick = 0;
        repeat (2) cyc();
        check("tick0 we held", {31'd0, bus.rf_we}, 32'd1);
        check("tick0 waddr held", {27'd0, bus.rf_waddr}, 32'd12);
        Tick = 1;
        cyc();
        check("tick1 wdata", bus.rf_wdata, 32'h77);
        idle();

        issue(2'b01, 5'd5, 3'd2, 32'h4000);
        cyc();
        idle();
        check("pre-reset busy", {31'd0, bus.busy}, 32'd1);
        Reset = 1;
        #1;
        check("async reset busy", {31'd0, bus.busy}, 32'd0);
        check("async reset in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("async reset busy_rd", {27'd0, bus.busy_rd}, 32'd0);
        cyc();
        Reset = 0;
        bus.dmem_ready = 1;
        cyc();
        check("post-reset no write", {31'd0, bus.rf_we}, 32'd0);
        idle();
        repeat (2) cyc();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
